// File: rtl/treg_byte_server.sv
// treg_byte_server: tile-register file with a byte-serial read port.
// Rows are written whole; a read request streams one register byte by byte.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   wr_en          write one full row this cycle
//   wr_address     register to write
//   wr_row         row to write
//   wr_data        row data, byte 0 in [7:0]
//   read_req       level request, held while streaming
//   read_mode      00/11 row-major, 01 column-major, 10 upper half rows
//   read_address   register to stream
//   read_data      streamed byte
//   read_valid     read_data valid this cycle
//   row_last       last byte of a row (row-major) or column (column-major)
//   reg_last       last byte of the transfer, held while in DONE
//   busy           transfer in progress or done but not yet released
module treg_byte_server #(
  parameter int NUM_REGS  = 8,
  parameter int ROWS      = 4,
  parameter int ROW_BYTES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]   wr_address,
  input  logic [$clog2(ROWS)-1:0]       wr_row,
  input  logic [8*ROW_BYTES-1:0]        wr_data,
  input  logic                          read_req,
  input  logic [1:0]                    read_mode,
  input  logic [$clog2(NUM_REGS)-1:0]   read_address,
  output logic [7:0]                    read_data,
  output logic                          read_valid,
  output logic                          row_last,
  output logic                          reg_last,
  output logic                          busy
);

  localparam int AW  = $clog2(NUM_REGS);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(ROW_BYTES);
  localparam int NW  = $clog2(ROWS * ROW_BYTES) + 1;
  localparam int AW1 = AW + 1;
  localparam int RW1 = RW + 1;

  localparam logic [NW-1:0]  L_FULL  = NW'(ROWS * ROW_BYTES - 1);
  localparam logic [NW-1:0]  L_HALF  = NW'(ROWS * ROW_BYTES / 2 - 1);
  localparam logic [NW-1:0]  NW_ONE  = NW'(1);
  localparam logic [RW-1:0]  R_MAX   = RW'(ROWS - 1);
  localparam logic [RW-1:0]  R_ONE   = RW'(1);
  localparam logic [CW-1:0]  C_MAX   = CW'(ROW_BYTES - 1);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);
  localparam logic [AW1-1:0] NREGS_W = AW1'(NUM_REGS);
  localparam logic [RW1-1:0] NROWS_W = RW1'(ROWS);

  localparam logic [1:0] M_COL  = 2'b01;
  localparam logic [1:0] M_HALF = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_e;

  // Register storage, one packed row per entry; never reset.
  logic [8*ROW_BYTES-1:0] mem_q [NUM_REGS][ROWS];

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [1:0]     mode_q, mode_d;
  logic [RW-1:0]  r_q, r_d;
  logic [CW-1:0]  c_q, c_d;
  logic [NW-1:0]  cnt_q, cnt_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           rlast_q, rlast_d;
  logic           glast_q, glast_d;

  logic                   wr_ok;
  logic                   addr_ok;
  logic                   col_major;
  logic                   half;
  logic                   byte_last;
  logic                   row_end;
  logic [8*ROW_BYTES-1:0] cur_row;
  logic [7:0]             cur_byte;

  // Out-of-range indices only exist for non-power-of-2 sizes.
  assign wr_ok = ({1'b0, wr_address} < NREGS_W)
               && ({1'b0, wr_row} < NROWS_W);

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem_q[wr_address][wr_row] <= wr_data;
    end
  end

  assign addr_ok   = {1'b0, addr_q} < NREGS_W;
  assign col_major = (mode_q == M_COL);
  assign half      = (mode_q == M_HALF);
  assign byte_last = (cnt_q == (half ? L_HALF : L_FULL));
  assign row_end   = col_major ? (r_q == R_MAX) : (c_q == C_MAX);

  // Read sees the array before this edge's write: read-before-write.
  assign cur_row  = mem_q[addr_q][r_q];
  assign cur_byte = addr_ok ? cur_row[{c_q, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mode_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rlast_q <= 1'b0;
      glast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rlast_q <= rlast_d;
      glast_q <= glast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    data_d  = 8'h00;
    valid_d = 1'b0;
    rlast_d = 1'b0;
    glast_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (read_req) begin
          addr_d  = read_address;
          mode_d  = read_mode;
          r_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (!read_req) begin
          state_d = S_IDLE;
        end else begin
          data_d  = cur_byte;
          valid_d = 1'b1;
          rlast_d = row_end;
          glast_d = byte_last;
          cnt_d   = cnt_q + NW_ONE;
          if (byte_last) begin
            state_d = S_DONE;
          end else if (col_major) begin
            // Column-major: rows inner, columns outer.
            if (r_q == R_MAX) begin
              r_d = '0;
              c_d = c_q + C_ONE;
            end else begin
              r_d = r_q + R_ONE;
            end
          end else begin
            if (c_q == C_MAX) begin
              c_d = '0;
              r_d = r_q + R_ONE;
            end else begin
              c_d = c_q + C_ONE;
            end
          end
        end
      end

      S_DONE: begin
        if (read_req) begin
          glast_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign read_data  = data_q;
  assign read_valid = valid_q;
  assign row_last   = rlast_q;
  assign reg_last   = glast_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_treg_byte_server.sv
// tb_treg_byte_server: directed and randomized streams of the tile registers,
// checked against a byte-array model of the register contents.
module tb_treg_byte_server;

  localparam int NR = 8;
  localparam int RO = 4;
  localparam int RB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_address;
  logic [1:0]  wr_row;
  logic [63:0] wr_data;
  logic        read_req;
  logic [1:0]  read_mode;
  logic [2:0]  read_address;
  logic [7:0]  read_data;
  logic        read_valid;
  logic        row_last;
  logic        reg_last;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic [7:0] mdl [NR][RO][RB];

  always #5 clk = ~clk;

  treg_byte_server #(
    .NUM_REGS (NR),
    .ROWS     (RO),
    .ROW_BYTES(RB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_address   (wr_address),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .read_req     (read_req),
    .read_mode    (read_mode),
    .read_address (read_address),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .row_last     (row_last),
    .reg_last     (reg_last),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] o,
                      input logic [7:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
  endtask

  task automatic all_zero(input string tag);
    chk8({tag, "_data"}, read_data, 8'h00);
    chk1({tag, "_valid"}, read_valid, 1'b0);
    chk1({tag, "_rowlast"}, row_last, 1'b0);
    chk1({tag, "_reglast"}, reg_last, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic mwr(input int a, input int r, input logic [63:0] d);
    for (int b = 0; b < RB; b++) mdl[a][r][b] = d[8*b +: 8];
  endtask

  task automatic wr(input int a, input int r, input logic [63:0] d);
    wr_en      = 1'b1;
    wr_address = 3'(a);
    wr_row     = 2'(r);
    wr_data    = d;
    tick();
    wr_en = 1'b0;
    mwr(a, r, d);
  endtask

  // One transfer. abort_at / rst_at: byte index at which read_req drops or
  // reset is raised instead of taking that byte (-1 = never). fj: byte
  // index whose edge also writes row frow of the register being read.
  task automatic xfer(input int a, input int m, input int abort_at,
                      input int rst_at, input bit rst_done,
                      input int fj, input int frow,
                      input logic [63:0] fd, input bit rndw);
    int n;
    bit col;
    int r;
    int c;
    logic [7:0] eb;
    bit wrote;
    int wa;
    int wrw;
    logic [63:0] wd;
    n   = (m == 2) ? RO * RB / 2 : RO * RB;
    col = (m == 1);
    wa  = 0;
    wrw = 0;
    wd  = '0;
    read_req     = 1'b1;
    read_address = 3'(a);
    read_mode    = 2'(m);
    tick();
    chk1("req_busy", busy, 1'b1);
    chk1("req_valid", read_valid, 1'b0);
    for (int j = 0; j < n; j++) begin
      read_address = 3'($urandom);
      read_mode    = 2'($urandom);
      if (j == abort_at) begin
        read_req = 1'b0;
        tick();
        chk1("abort_valid", read_valid, 1'b0);
        chk1("abort_rowlast", row_last, 1'b0);
        chk1("abort_reglast", reg_last, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        return;
      end
      if (j == rst_at) begin
        rst = 1'b1;
        tick();
        all_zero("rst_stream");
        rst      = 1'b0;
        read_req = 1'b0;
        tick();
        chk1("rst_stream_idle", busy, 1'b0);
        return;
      end
      r  = col ? j % RO : j / RB;
      c  = col ? j / RO : j % RB;
      eb = mdl[a][r][c];
      wrote = 1'b0;
      if (j == fj) begin
        wa = a;
        wrw = frow;
        wd = fd;
        wrote = 1'b1;
      end else if (rndw && $urandom_range(0, 2) == 0) begin
        wa  = $urandom_range(0, NR - 1);
        wrw = $urandom_range(0, RO - 1);
        wd  = {$urandom, $urandom};
        wrote = 1'b1;
      end
      wr_en = wrote;
      if (wrote) begin
        wr_address = 3'(wa);
        wr_row     = 2'(wrw);
        wr_data    = wd;
      end
      tick();
      wr_en = 1'b0;
      if (wrote) mwr(wa, wrw, wd);
      chk8("data", read_data, eb);
      chk1("valid", read_valid, 1'b1);
      chk1("row_last", row_last, col ? (r == RO - 1) : (c == RB - 1));
      chk1("reg_last", reg_last, j == n - 1);
    end
    tick();
    chk1("done_valid", read_valid, 1'b0);
    chk1("done_rowlast", row_last, 1'b0);
    chk1("done_reglast", reg_last, 1'b1);
    chk1("done_busy", busy, 1'b1);
    if (rst_done) begin
      rst = 1'b1;
      tick();
      all_zero("rst_done");
      rst      = 1'b0;
      read_req = 1'b0;
      tick();
      chk1("rst_done_idle", busy, 1'b0);
      return;
    end
    tick();
    chk1("hold_reglast", reg_last, 1'b1);
    chk1("hold_busy", busy, 1'b1);
    read_req = 1'b0;
    tick();
    chk1("rel_reglast", reg_last, 1'b0);
    chk1("rel_valid", read_valid, 1'b0);
    chk1("rel_busy", busy, 1'b0);
  endtask

  logic [63:0] pat;

  initial begin
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_address   = '0;
    wr_row       = '0;
    wr_data      = '0;
    read_req     = 1'b0;
    read_mode    = '0;
    read_address = '0;
    tick();
    tick();
    all_zero("reset");
    rst = 1'b0;

    for (int a = 0; a < NR; a++) begin
      for (int r = 0; r < RO; r++) begin
        for (int b = 0; b < RB; b++) begin
          pat[8*b +: 8] = (a == 2) ? 8'(8 * r + b) : 8'($urandom);
        end
        wr(a, r, pat);
      end
    end
    tick();
    all_zero("idle_after_wr");

    xfer(2, 0, -1, -1, 1'b0, -1, 0, '0, 1'b0);
    xfer(2, 1, -1, -1, 1'b0, -1, 0, '0, 1'b0);
    xfer(2, 2, -1, -1, 1'b0, -1, 0, '0, 1'b0);
    xfer(2, 3, -1, -1, 1'b0, -1, 0, '0, 1'b0);
    xfer(2, 0, 5, -1, 1'b0, -1, 0, '0, 1'b0);
    xfer(3, 0, -1, -1, 1'b0, -1, 0, '0, 1'b0);
    xfer(2, 0, -1, -1, 1'b0, 24, 3, {8{8'hAA}}, 1'b0);
    xfer(2, 1, -1, 9, 1'b0, -1, 0, '0, 1'b0);
    xfer(2, 0, -1, -1, 1'b1, -1, 0, '0, 1'b0);
    xfer(2, 0, -1, -1, 1'b0, -1, 0, '0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      xfer($urandom_range(0, NR - 1), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1,
           -1, 1'b0, -1, 0, '0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
